// File: rtl/router_egress_arbiter.sv
// Egress arbiter for the 1x3 router: round-robin, per-packet grant of one FIFO
// onto a shared 8-bit downstream channel through a 2-entry output buffer.
module router_egress_arbiter #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned TO_W    = 6
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] valid_out,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic [2:0] read_enb,
    input  logic       out_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       sop,
    output logic       eop,
    output logic [2:0] grant,
    output logic       pkt_abort
);

    typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [1:0]      g_idx;
    logic [6:0]      remain;
    logic [TO_W-1:0] stall_cnt;
    logic            inflight;
    logic            inflight_eop;
    logic [9:0]      buf_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;

    logic            pop;
    logic            push;
    logic            space;
    logic            rd;
    logic            stall;
    logic [1:0]      sel;
    logic [1:0]      rd_idx;
    logic [1:0]      c1;
    logic [1:0]      c2;
    logic [2:0]      occ;
    logic [7:0]      rdata;
    logic [9:0]      head;
    logic [TO_W-1:0] stall_nxt;

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        case (g_idx)
            2'd1:    rdata = data_out_1;
            2'd2:    rdata = data_out_2;
            default: rdata = data_out_0;
        endcase
    end

    // Output buffer occupancy counts the byte still in flight from the FIFO
    assign head       = buf_mem[rd_ptr];
    assign dout_valid = (count != 2'd0);
    assign dout       = dout_valid ? head[9:2] : '0;
    assign sop        = dout_valid & head[1];
    assign eop        = dout_valid & head[0];
    assign pop        = dout_valid & out_ready;
    assign push       = inflight;
    assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign space      = (occ < 3'd2);

    assign c1 = nxt(ptr);
    assign c2 = nxt(c1);

    always_comb begin
        sel = c2;
        if (valid_out[ptr])
            sel = ptr;
        else if (valid_out[c1])
            sel = c1;
    end

    always_comb begin
        rd     = 1'b0;
        rd_idx = g_idx;
        case (state)
            IDLE: begin
                rd     = space & (|valid_out);
                rd_idx = sel;
            end
            XFER:    rd = valid_out[g_idx] & (remain != 7'd0) & space;
            default: rd = 1'b0;
        endcase
    end

    // Strobes are combinational, so they are also forced low while reset is held
    assign read_enb  = (rd & resetn) ? (3'b001 << rd_idx) : '0;
    assign stall     = (state == XFER) & (remain != 7'd0) & ~valid_out[g_idx] & ~inflight;
    assign stall_nxt = stall_cnt + 1'b1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            ptr          <= '0;
            g_idx        <= '0;
            remain       <= '0;
            stall_cnt    <= '0;
            inflight     <= 1'b0;
            inflight_eop <= 1'b0;
            buf_mem[0]   <= '0;
            buf_mem[1]   <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= '0;
            grant        <= '0;
            pkt_abort    <= 1'b0;
        end else begin
            pkt_abort    <= 1'b0;
            inflight     <= rd;
            inflight_eop <= rd & (state == XFER) & (remain == 7'd1);
            if (push) begin
                buf_mem[wr_ptr] <= {rdata, state == HDR, inflight_eop};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (rd) begin
                        g_idx <= sel;
                        grant <= 3'b001 << sel;
                        state <= HDR;
                    end
                end
                HDR: begin
                    remain    <= {1'b0, rdata[7:2]} + 7'd1;
                    stall_cnt <= '0;
                    state     <= XFER;
                end
                XFER: begin
                    if (rd)
                        remain <= remain - 7'd1;
                    if (remain == 7'd0 && !inflight) begin
                        state     <= IDLE;
                        ptr       <= nxt(g_idx);
                        grant     <= '0;
                        stall_cnt <= '0;
                    end else if (stall) begin
                        if (stall_nxt == TO_W'(TIMEOUT)) begin
                            pkt_abort <= 1'b1;
                            state     <= IDLE;
                            ptr       <= nxt(g_idx);
                            grant     <= '0;
                            remain    <= '0;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_nxt;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Bench for router_egress_arbiter: behavioural router FIFOs plus a scoreboard of
// expected downstream {data, sop, eop} entries.
module tb_router_egress_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] valid_out = '0;
    logic [7:0] dq [3];
    logic [2:0] read_enb;
    logic       out_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       sop;
    logic       eop;
    logic [2:0] grant;
    logic       pkt_abort;

    logic [7:0] fq [3][$];
    logic [9:0] exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         reads_seen [3] = '{0, 0, 0};
    int         outstanding = 0;

    router_egress_arbiter #(.TIMEOUT(32), .TO_W(6)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .valid_out  (valid_out),
        .data_out_0 (dq[0]),
        .data_out_1 (dq[1]),
        .data_out_2 (dq[2]),
        .read_enb   (read_enb),
        .out_ready  (out_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sop        (sop),
        .eop        (eop),
        .grant      (grant),
        .pkt_abort  (pkt_abort)
    );

    always #5 clock = ~clock;

    // Router FIFO model: one-cycle read latency, not-empty flag per FIFO
    always @(posedge clock) begin : fifo_model
        logic [2:0] re;
        logic [2:0] vo;
        re = read_enb;
        for (int i = 0; i < 3; i++) begin
            if (re[i] && fq[i].size() != 0)
                dq[i] <= fq[i].pop_front();
        end
        for (int i = 0; i < 3; i++)
            vo[i] = (fq[i].size() != 0);
        valid_out <= vo;
    end

    always @(negedge clock) begin : monitor
        logic [9:0] e;
        if (!resetn) begin
            outstanding = 0;
        end else begin
            checks++;
            if (((read_enb & ~valid_out) != 3'b000) || ((read_enb & (read_enb - 3'd1)) != 3'b000)) begin
                failures++;
                $display("FAIL read_enb_legal got read_enb=%b valid_out=%b need one-hot/zero within valid", read_enb, valid_out);
            end
            if (read_enb != 3'b000) begin
                outstanding++;
                for (int i = 0; i < 3; i++)
                    if (read_enb[i]) reads_seen[i]++;
            end
            if (dout_valid && out_ready) begin
                outstanding--;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got dout=%h sop=%b eop=%b need no byte", dout, sop, eop);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout, sop, eop} !== e) begin
                        failures++;
                        $display("FAIL sb_byte got dout=%h sop=%b eop=%b need dout=%h sop=%b eop=%b",
                                 dout, sop, eop, e[9:2], e[1], e[0]);
                    end
                end
            end
            checks++;
            if (outstanding > 2) begin
                failures++;
                $display("FAIL buffer_bound got outstanding=%0d need <=2", outstanding);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Loads header/payload/parity into FIFO f and queues the expected downstream bytes
    task automatic load_pkt(input int f, input int len, input logic [7:0] base, input int n_pl);
        logic [7:0] hdr;
        logic [7:0] b;
        logic [7:0] p;
        hdr = {6'(len), 2'(f)};
        p   = hdr;
        fq[f].push_back(hdr);
        exp_q.push_back({hdr, 2'b10});
        for (int k = 0; k < n_pl; k++) begin
            b = base + 8'(k * 17);
            p = p ^ b;
            fq[f].push_back(b);
            exp_q.push_back({b, 2'b00});
        end
        if (n_pl == len) begin
            fq[f].push_back(p);
            exp_q.push_back({p, 2'b01});
        end
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && grant == 3'b000 && !dout_valid && read_enb == 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
        tick(1);
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        out_ready = 1'b1;
        tick(2);
        @(negedge clock);
        checks++;
        if ({read_enb, grant} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got read_enb=%b grant=%b need 0", read_enb, grant);
        end
        checks++;
        if ({dout, dout_valid, sop, eop, pkt_abort} !== 12'b0) begin
            failures++;
            $display("FAIL reset_out got dout=%h v=%b sop=%b eop=%b abort=%b need 0", dout, dout_valid, sop, eop, pkt_abort);
        end
        tick(1);
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_single_packet();
        int r0;
        bit saw;
        bit bad;
        bit ok;
        logic [2:0] first;
        r0 = reads_seen[1];
        saw = 1'b0;
        bad = 1'b0;
        ok = 1'b0;
        load_pkt(1, 3, 8'h11, 3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (grant == 3'b010) saw = 1'b1;
            else if (grant != 3'b000) bad = 1'b1;
            if (saw && grant == 3'b000 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_done got pending=%0d need 0 within budget", exp_q.size());
        end
        checks++;
        if (!saw || bad) begin
            failures++;
            $display("FAIL single_grant got saw010=%b other=%b need 1/0", saw, bad);
        end
        checks++;
        if (reads_seen[1] - r0 !== 5) begin
            failures++;
            $display("FAIL single_reads got %0d need 5", reads_seen[1] - r0);
        end
        // Pointer now at 2: FIFO2 must win over FIFO0
        tick(1);
        load_pkt(2, 1, 8'h40, 1);
        load_pkt(0, 1, 8'h50, 1);
        first = 3'b000;
        for (int i = 0; i < 20 && first == 3'b000; i++) begin
            @(negedge clock);
            first = grant;
        end
        checks++;
        if (first !== 3'b100) begin
            failures++;
            $display("FAIL ptr_after_single got grant=%b need 100", first);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ptr_drain got pending=%0d need 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [$];
        logic [2:0] last;
        bit ok;
        resetn = 1'b0;
        tick(1);
        load_pkt(0, 1, 8'h21, 1);
        load_pkt(1, 1, 8'h31, 1);
        load_pkt(2, 1, 8'h41, 1);
        tick(3);
        resetn = 1'b1;
        last = 3'b000;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (grant != last && grant != 3'b000) seq.push_back(grant);
            last = grant;
            if (seq.size() >= 3 && grant == 3'b000 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || seq.size() != 3) begin
            failures++;
            $display("FAIL rr_done got grants=%0d pending=%0d need 3/0", seq.size(), exp_q.size());
        end else begin
            checks++;
            if (seq[0] !== 3'b001 || seq[1] !== 3'b010 || seq[2] !== 3'b100) begin
                failures++;
                $display("FAIL rr_order got %b %b %b need 001 010 100", seq[0], seq[1], seq[2]);
            end
        end
        checks++;
        if (grant !== 3'b000) begin
            failures++;
            $display("FAIL rr_final_grant got %b need 000", grant);
        end
        tick(1);
    endtask

    task automatic test_backpressure();
        int r0;
        bit ok;
        r0 = reads_seen[2];
        out_ready = 1'b0;
        load_pkt(2, 2, 8'h60, 2);
        repeat (12) @(negedge clock);
        checks++;
        if (reads_seen[2] - r0 !== 2) begin
            failures++;
            $display("FAIL bp_reads_stalled got %0d need 2", reads_seen[2] - r0);
        end
        checks++;
        if (!dout_valid || !sop || dout !== 8'h0A) begin
            failures++;
            $display("FAIL bp_head got v=%b sop=%b dout=%h need 1 1 0a", dout_valid, sop, dout);
        end
        tick(1);
        out_ready = 1'b1;
        wait_idle(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_drain got pending=%0d need 0", exp_q.size());
        end
        checks++;
        if (reads_seen[2] - r0 !== 4) begin
            failures++;
            $display("FAIL bp_reads_total got %0d need 4", reads_seen[2] - r0);
        end
    endtask

    task automatic test_zero_len();
        int r0;
        bit ok;
        r0 = reads_seen[0];
        load_pkt(0, 0, 8'h00, 0);
        wait_idle(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL zero_len_done got pending=%0d grant=%b need 0/000", exp_q.size(), grant);
        end
        checks++;
        if (reads_seen[0] - r0 !== 2) begin
            failures++;
            $display("FAIL zero_len_reads got %0d need 2", reads_seen[0] - r0);
        end
    endtask

    task automatic test_timeout();
        bit got;
        bit ok;
        bit saw1;
        bit early1;
        int cyc;
        int b_cyc;
        int a_cyc;
        int pulses;
        load_pkt(0, 5, 8'h70, 2);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = (grant == 3'b001);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL to_grant0 got grant=%b need 001", grant);
        end
        tick(1);
        load_pkt(1, 1, 8'hC0, 1);
        cyc = 0;
        b_cyc = -1;
        a_cyc = -1;
        pulses = 0;
        saw1 = 1'b0;
        early1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            cyc++;
            if (dout_valid && dout == 8'h81 && b_cyc < 0) b_cyc = cyc;
            if (pkt_abort) begin
                pulses++;
                if (a_cyc < 0) a_cyc = cyc;
            end
            if (grant == 3'b010) begin
                saw1 = 1'b1;
                if (a_cyc < 0) early1 = 1'b1;
            end
            if (saw1 && grant == 3'b000 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (b_cyc < 0 || a_cyc < 0 || a_cyc - b_cyc != 32) begin
            failures++;
            $display("FAIL to_latency got last_byte=%0d abort=%0d need abort-last=32", b_cyc, a_cyc);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL to_pulse got %0d cycles need 1", pulses);
        end
        checks++;
        if (!saw1 || early1) begin
            failures++;
            $display("FAIL to_next_grant got saw010=%b before_abort=%b need 1/0", saw1, early1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL to_drain got pending=%0d need 0", exp_q.size());
        end
        tick(1);
    endtask

    task automatic test_reset_mid();
        bit got;
        bit ok;
        logic [2:0] first;
        load_pkt(0, 4, 8'hA0, 4);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = (grant == 3'b001);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL mid_grant0 got grant=%b need 001", grant);
        end
        repeat (3) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({read_enb, grant, pkt_abort} !== 7'b0) begin
            failures++;
            $display("FAIL mid_reset_ctrl got read_enb=%b grant=%b abort=%b need 0", read_enb, grant, pkt_abort);
        end
        checks++;
        if ({dout, dout_valid, sop, eop} !== 11'b0) begin
            failures++;
            $display("FAIL mid_reset_out got dout=%h v=%b sop=%b eop=%b need 0", dout, dout_valid, sop, eop);
        end
        fq[0].delete();
        exp_q.delete();
        tick(1);
        load_pkt(1, 1, 8'hD0, 1);
        load_pkt(2, 1, 8'hE0, 1);
        tick(3);
        resetn = 1'b1;
        first = 3'b000;
        for (int i = 0; i < 20 && first == 3'b000; i++) begin
            @(negedge clock);
            first = grant;
        end
        checks++;
        if (first !== 3'b010) begin
            failures++;
            $display("FAIL mid_first_grant got %b need 010", first);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mid_drain got pending=%0d need 0", exp_q.size());
        end
    endtask

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_zero_len();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/router_egress_arbiter.md
Name: router_egress_arbiter

Overview:
- Drains the three output FIFOs of the 1x3 router onto one shared 8-bit downstream channel.
- Generates `read_enb[2:0]` for the router from its `valid_out[2:0]`.
- Grants one FIFO per whole packet, with round-robin fairness between the three FIFOs.
- Packet format on the FIFO side: header byte (`[7:2]` payload length, `[1:0]` address), then payload bytes, then one parity byte.

Parameters:
- `TIMEOUT`, default 32: consecutive stalled cycles inside a packet (granted `valid_out` low, nothing in flight) before the packet is aborted.
- `TO_W`, default 6: width of the stall counter; must hold `TIMEOUT`.

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `valid_out`  in  3  per-FIFO not-empty from the router
- `data_out_0`  in  8  FIFO 0 read data, valid the cycle after `read_enb[0]`
- `data_out_1`  in  8  FIFO 1 read data, same timing
- `data_out_2`  in  8  FIFO 2 read data, same timing
- `read_enb`  out  3  FIFO read strobes to the router, at most one bit high
- `out_ready`  in  1  downstream can accept a byte this cycle
- `dout`  out  8  downstream data
- `dout_valid`  out  1  `dout` valid; a byte transfers when `dout_valid` and `out_ready` are both high
- `sop`  out  1  `dout` is a header byte
- `eop`  out  1  `dout` is a parity byte
- `grant`  out  3  one-hot FIFO currently owned, 0 in IDLE
- `pkt_abort`  out  1  one-cycle pulse when a packet is abandoned on timeout

Behaviour:
- Reset (async, `resetn` low):
  - `read_enb`, `dout`, `dout_valid`, `sop`, `eop`, `grant`, `pkt_abort` all 0.
  - State IDLE, round-robin pointer `ptr` = 0, output buffer empty, `remain` = 0, stall counter = 0, inflight = 0.
- FIFO read latency is 1 cycle. `inflight` is a registered flag set in the cycle `read_enb` is high; the returned byte is pushed into the output buffer on the next edge.
- Output buffer: 2-entry FIFO of {data, sop, eop}; `dout`, `sop` and `eop` show its head.
  - `pop` = `dout_valid` and `out_ready`.
  - `space` = (count + inflight − pop) < 2.
  - Push and pop in the same cycle leaves the count unchanged.
- FSM, IDLE:
  - If `space` and any `valid_out` bit is set, select the first set bit searching `ptr`, `ptr`+1, `ptr`+2 (mod 3).
  - For the selected FIFO g: set `grant` = g, assert `read_enb[g]` for 1 cycle (header read), go to HDR.
  - Otherwise stay in IDLE with `read_enb` = 0.
- FSM, HDR:
  - No read is issued.
  - The header byte arrives and is pushed with `sop` = 1.
  - Load `remain` = header`[7:2]` + 1 (payload plus parity; 7-bit counter, range 1..64).
  - Go to XFER.
- FSM, XFER:
  - `read_enb[g]` = `valid_out[g]` and (`remain` != 0) and `space`; `remain` decrements on each read.
  - The byte read when `remain` == 1 is pushed with `eop` = 1.
  - When `remain` == 0 and `inflight` == 0: go to IDLE, set `ptr` = (g+1) mod 3, clear `grant`.
  - A header length of 0 gives a 2-byte packet (header, parity).
- Stall and timeout:
  - In XFER, the stall counter increments each cycle in which `remain` != 0, `valid_out[g]` == 0 and `inflight` == 0; it clears otherwise.
  - When the counter reaches `TIMEOUT`: pulse `pkt_abort`, go to IDLE, set `ptr` = (g+1) mod 3.
  - Bytes already buffered still drain. No `eop` is generated for an aborted packet.
- Grant hold rules:
  - `grant` never changes mid-packet.
  - `valid_out` of other FIFOs is ignored while in HDR or XFER.
  - Downstream backpressure (`out_ready` low) stalls reads through `space`; it never drops a byte.
- Invariants:
  - `read_enb` is one-hot or zero.
  - `read_enb[i]` is never asserted while `valid_out[i]` == 0.
  - The output buffer never overflows.
- Reset mid-packet: everything returns to reset values immediately. The partially read FIFO is left for the router's own soft-reset.

Test Plan:
- FIFO 1 holds header `8'h0D` (len 3, addr 1), payload `11 22 33`, parity `P`; `out_ready`=1 → `grant`=3'b010; downstream sees `0D`(`sop`), `11`, `22`, `33`, `P`(`eop`); exactly 5 `read_enb[1]` pulses; then `ptr`=2.
- All three FIFOs hold a len-1 packet at reset release, `out_ready`=1 → packets leave in order FIFO0, FIFO1, FIFO2; `grant` transitions 001 → 010 → 100 → 000.
- Len-2 packet on FIFO 2, `out_ready` low for 10 cycles after the header → at most 2 bytes buffered, no read while the buffer is full, all 4 bytes delivered intact once `out_ready` rises.
- Header `8'h00` on FIFO 0 → 2-byte packet (header, parity), `eop` on the second byte, return to IDLE.
- FIFO 0 granted, header len 5, `valid_out[0]` drops after 2 payload bytes and stays low → `pkt_abort` pulses exactly `TIMEOUT` (32) cycles after the last read returns; FSM back to IDLE with `ptr`=1; FIFO 1's pending packet is then granted.
- Assert `resetn`=0 mid-XFER → all outputs 0 asynchronously; after release the first grant goes to the lowest-indexed valid FIFO.
